// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: byte FIFO written over the bus, 8N1 serializer,
// and a STATUS register with a sticky overflow flag.
module uart_tx_periph #(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Select,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  tx
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [BAUD_W-1:0] baud_r, baud_s;
    logic [2:0]        bit_idx_r, bit_idx_s;
    logic [7:0]        shift_r, shift_s;
    logic              tx_r, tx_s;

    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;

    logic              push_req_s, stat_wr_s, accept_s, pop_s, ovf_set_s;
    logic              full_s, empty_s, busy_s, baud_last_s;
    logic [7:0]        head_s;
    logic [2:0]        cnt3_s;
    logic              unused_s;

    assign unused_s = ^{Address[DATA_WIDTH-1:4], Address[1:0], WriteData[DATA_WIDTH-1:8]};

    // Bus decode and FIFO flow control; a pop frees a slot for a push on the same edge.
    always_comb begin
        push_req_s = Select & MemWrite & (Address[3:2] == 2'd0);
        stat_wr_s  = Select & MemWrite & (Address[3:2] == 2'd1);
        full_s     = (count_r == CNT_FULL);
        empty_s    = (count_r == {CNT_W{1'b0}});
        busy_s     = (state_r != ST_IDLE);
        head_s     = mem_r[rd_ptr_r];
        cnt3_s     = 3'(count_r);
        accept_s   = push_req_s & (~full_s | pop_s);
        ovf_set_s  = push_req_s & ~accept_s;
    end

    // Serializer next-state logic; tx_s is the value the line takes after this edge.
    always_comb begin
        state_s     = state_r;
        baud_s      = baud_r;
        bit_idx_s   = bit_idx_r;
        shift_s     = shift_r;
        tx_s        = tx_r;
        pop_s       = 1'b0;
        baud_last_s = (baud_r == BAUD_LAST);
        case (state_r)
            ST_IDLE: begin
                tx_s = 1'b1;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    state_s = ST_START;
                    tx_s    = 1'b0;
                    baud_s  = {BAUD_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_s    = {BAUD_W{1'b0}};
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                    tx_s      = shift_r[0];
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_s = {BAUD_W{1'b0}};
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        tx_s      = shift_r[1];
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_s    = {BAUD_W{1'b0}};
                    bit_idx_s = 3'd0;
                    // Chain straight into the next start bit so queued bytes leave no idle gap.
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_s = head_s;
                        state_s = ST_START;
                        tx_s    = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                        tx_s    = 1'b1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s   = ST_IDLE;
                baud_s    = {BAUD_W{1'b0}};
                bit_idx_s = 3'd0;
                shift_s   = 8'd0;
                tx_s      = 1'b1;
            end
        endcase
    end

    // Serializer state register; tx comes straight from tx_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            tx_r      <= tx_s;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (stat_wr_s && WriteData[3]) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= WriteData[7:0];
        end
    end

    // Load path decode.
    always_comb begin
        case (Address[3:2])
            2'd0:    ReadData = {DATA_WIDTH{1'b0}};
            2'd1:    ReadData = {{(DATA_WIDTH-7){1'b0}}, cnt3_s, overflow_r, empty_s, full_s, busy_s};
            default: ReadData = {DATA_WIDTH{1'b0}};
        endcase
    end

    assign tx = tx_r;
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: random bus traffic against a queue/timer reference model,
// with a line monitor that decodes frames and checks them against a scoreboard.
module tb_uart_tx_periph;
    localparam int DW    = 32;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic          Select;
    logic          MemWrite;
    logic [DW-1:0] Address;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadData;
    logic          tx;

    uart_tx_periph #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .Select(Select), .Address(Address),
        .WriteData(WriteData), .MemWrite(MemWrite), .ReadData(ReadData), .tx(tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: FIFO contents, cycles left in the current frame, overflow flag.
    logic [7:0] m_fifo[$];
    logic [7:0] exp_q[$];
    int         m_left = 0;
    bit         m_ovf = 1'b0;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    // Monitor state
    bit         mon_active = 1'b0;
    int         mon_cyc = 0;
    bit         mon_err = 1'b0;
    logic [7:0] mon_exp = 8'd0;
    logic [7:0] mon_got = 8'd0;
    int         mon_frames = 0;
    int         last_end = 0;
    int         last_gap = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'd0;
        s[0]   = (m_left > 0);
        s[1]   = (m_fifo.size() == DEPTH);
        s[2]   = (m_fifo.size() == 0);
        s[3]   = m_ovf;
        s[6:4] = 3'(m_fifo.size());
        return s;
    endfunction

    // One clock edge of the model: the transmitter takes a byte when idle or on the
    // last cycle of a frame; a full FIFO only takes a push if that happens on the same edge.
    task automatic model_edge(input bit push, input logic [7:0] d, input bit clr);
        int sz;
        bit pop_m, acc;
        sz    = m_fifo.size();
        pop_m = (sz > 0) && (m_left <= 1);
        acc   = push && ((sz < DEPTH) || pop_m);
        if (pop_m) void'(m_fifo.pop_front());
        if (acc) begin
            m_fifo.push_back(d);
            exp_q.push_back(d);
        end
        if (push && !acc) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (pop_m) m_left = FRAME;
        else if (m_left > 0) m_left--;
    endtask

    task automatic read_status(input string name);
        MemWrite = 1'b0;
        Address  = $urandom;
        Address[3:2] = 2'd1;
        #1;
        check(name, ReadData, model_status());
    endtask

    task automatic step(input bit push, input logic [7:0] d, input bit clr);
        int kind;
        logic [1:0] ra;
        Select    = 1'b1;
        MemWrite  = 1'b0;
        Address   = $urandom;
        WriteData = $urandom;
        if (push) begin
            Address[3:2]   = 2'd0;
            MemWrite       = 1'b1;
            WriteData[7:0] = d;
        end else if (clr) begin
            Address[3:2] = 2'd1;
            MemWrite     = 1'b1;
            WriteData[3] = 1'b1;
        end else begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin Select = 1'b0; MemWrite = 1'b1; Address[3:2] = 2'd0; end
                1: begin MemWrite = 1'b1; Address[3:2] = 2'd2 + 2'($urandom_range(0, 1)); end
                2: begin MemWrite = 1'b1; Address[3:2] = 2'd1; WriteData[3] = 1'b0; end
                default: MemWrite = 1'b0;
            endcase
        end
        model_edge(push, d, clr);
        @(posedge clk);
        #1;
        Select   = $urandom;
        MemWrite = 1'b0;
        Address  = $urandom;
        ra       = Address[3:2];
        #1;
        check("readdata", ReadData, (ra == 2'd1) ? model_status() : 32'd0);
    endtask

    task automatic do_reset(input bit with_push);
        reset     = 1'b1;
        Select    = 1'b1;
        MemWrite  = with_push;
        Address   = 32'd0;
        WriteData = $urandom;
        m_fifo.delete();
        exp_q.delete();
        m_left = 0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        MemWrite = 1'b0;
        Address  = 32'h4;
        #1;
        check("reset_status", ReadData, 32'h4);
        check("reset_tx", {31'd0, tx}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_fifo.size() > 0 || m_left > 0) && n < 3000) begin
            step(1'b0, 8'd0, 1'b0);
            n++;
        end
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        check("drain_bound", {31'd0, n < 3000}, 32'd1);
    endtask

    task automatic wait_left(input int target);
        int n;
        n = 0;
        while (m_left != target && n < 200) begin
            step(1'b0, 8'd0, 1'b0);
            n++;
        end
        check("wait_bound", {31'd0, n < 200}, 32'd1);
    endtask

    // Line monitor: every cycle of a frame must match the scoreboard byte's 8N1 pattern.
    initial begin
        int b;
        logic expbit;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame got=start_bit exp=idle_line");
                    end else begin
                        mon_exp    = exp_q.pop_front();
                        mon_active = 1'b1;
                        mon_cyc    = 1;
                        mon_err    = 1'b0;
                        mon_got    = 8'd0;
                        last_gap   = cyc_cnt - last_end;
                    end
                end
            end else begin
                b = mon_cyc / CPB;
                if (b == 0) expbit = 1'b0;
                else if (b == 9) expbit = 1'b1;
                else expbit = mon_exp[b-1];
                if (tx !== expbit) mon_err = 1'b1;
                if ((mon_cyc % CPB) == (CPB / 2) && b >= 1 && b <= 8) mon_got[b-1] = tx;
                mon_cyc++;
                if (mon_cyc == FRAME) begin
                    checks++;
                    if (mon_err) begin
                        failures++;
                        $display("FAIL frame got=%h exp=%h (bit timing or framing wrong)", mon_got, mon_exp);
                    end
                    mon_active = 1'b0;
                    mon_frames++;
                    last_end = cyc_cnt;
                end
            end
        end
    end

    initial begin
        int frames0;
        reset = 1'b1; Select = 1'b0; MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
        @(posedge clk); #1;
        do_reset(1'b0);

        // Single byte 0xA5: one-edge latency, full frame, then idle status.
        frames0 = mon_frames;
        step(1'b1, 8'hA5, 1'b0);
        check("lat_tx_before", {31'd0, tx}, 32'd1);
        step(1'b0, 8'd0, 1'b0);
        check("lat_tx_start", {31'd0, tx}, 32'd0);
        repeat (FRAME - 1) step(1'b0, 8'd0, 1'b0);
        read_status("a5_busy_last");
        step(1'b0, 8'd0, 1'b0);
        read_status("a5_idle");
        check("a5_idle_const", ReadData, 32'h4);
        check("a5_frames", mon_frames, frames0 + 1);

        // Back-to-back pushes overflow the FIFO; then clear overflow via STATUS.
        repeat (6) step(1'b1, 8'($urandom), 1'b0);
        read_status("ovf_model");
        check("ovf_const", ReadData, 32'h4B);
        step(1'b0, 8'd0, 1'b1);
        read_status("ovf_clear");
        check("ovf_clear_bit", {31'd0, ReadData[3]}, 32'd0);
        drain();

        // Two queued bytes go out with no idle cycle between frames.
        frames0 = mon_frames;
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        drain();
        check("contig_frames", mon_frames, frames0 + 2);
        check("contig_gap", last_gap, 1);

        // Push on the STOP-to-START edge with a full FIFO is accepted.
        step(1'b1, 8'h11, 1'b0);
        repeat (4) step(1'b1, 8'($urandom), 1'b0);
        wait_left(1);
        step(1'b1, 8'h77, 1'b0);
        read_status("full_pop_push");
        check("full_pop_push_const", ReadData, 32'h43);
        drain();

        // Reset in the middle of data bit 3 aborts the frame and discards pending bytes.
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h0F, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        wait_left(FRAME - 17);
        do_reset(1'b1);
        frames0 = mon_frames;
        repeat (2 * FRAME) step(1'b0, 8'd0, 1'b0);
        check("no_frame_after_reset", mon_frames, frames0);

        // Random traffic.
        repeat (500) step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
        drain();
        check("scoreboard_empty", exp_q.size(), 0);
        check("monitor_idle", {31'd0, mon_active}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
